axis_stall_block_gen: RTL and testbench
=======================================

# axis_stall_block_gen

Per-channel AXI-stream stall detector that produces the `axis_block_sigs` vector consumed by the per-instance deadlock monitors. Each channel watches one AXIS handshake pair of an HLS instance and raises its block bit once that channel has been stalled for a programmable number of consecutive cycles. It sits beside each wrapped HLS instance, between the instance's stream ports and its deadlock monitor.

## Interface
Parameters:
- `N_CH`, 3: number of monitored AXIS channels.
- `THRESH`, 16: consecutive stalled cycles before a channel reports block; legal range is ≥1.
- `DIR_MASK`, 3'b001: per-channel direction. 1 = input channel (instance consumes). 0 = output channel (instance produces).
- `CNT_W`, $clog2(THRESH+1): stall counter width; derived, not overridden.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `axis_tvalid`  in  N_CH  tvalid of each monitored channel.
- `axis_tready`  in  N_CH  tready of each monitored channel.
- `inst_idle`  in  1  instance idle flag; forces all channels out of stall.
- `axis_block_sigs`  out  N_CH  registered per-channel block flags.
- `any_block`  out  1  registered OR of all block flags.
- `first_ch`  out  $clog2(N_CH) (min 1)  index of the first channel to enter BLOCKED since reset.
- `first_vld`  out  1  `first_ch` is valid.

## Operation
- Stall condition per channel c:
  - Input channel: `tready & ~tvalid` (instance starved).
  - Output channel: `tvalid & ~tready` (instance back-pressured).
  - Stall is always masked by `inst_idle`.
- Transfer: `tvalid & tready`.
- Per-channel FSM with states IDLE, STALL, BLOCKED:
  - IDLE: counter = 0. On a stall edge: counter <= 1. If THRESH == 1, go to BLOCKED; otherwise go to STALL.
  - STALL: on a stall edge, counter <= counter + 1. When the incremented value equals THRESH, go to BLOCKED. Any non-stall edge (transfer, neither side active, or `inst_idle`) returns to IDLE with counter cleared.
  - BLOCKED: counter holds at THRESH (saturates, never wraps). A transfer or `inst_idle` returns to IDLE. A non-stall edge with no transfer also returns to IDLE. Continued stall stays in BLOCKED.
- `axis_block_sigs[c]` = 1 exactly while channel c is in BLOCKED.
- `first_ch` / `first_vld`:
  - Captured on the first edge at which any channel enters BLOCKED.
  - If several channels enter on the same edge, the lowest index wins.
  - Held until reset and not updated by later blocks.
- Simultaneous transfer and `inst_idle` on the same edge: the result is IDLE either way.

## Timing
- Reset values: all FSMs in IDLE, counters 0, `axis_block_sigs` = 0, `any_block` = 0, `first_ch` = 0, `first_vld` = 0.
- Block latency: a stall that starts at edge k and continues uninterrupted makes `axis_block_sigs[c]` high after edge k+THRESH-1. That is, it is visible THRESH cycles after the stall is first sampled.
- Release latency: block drops the cycle after the edge that samples the transfer or `inst_idle`.
- `any_block` is registered from the next-state block vector, so it asserts on the same cycle as the block bits (no extra cycle).
- Reset asserted mid-stall: all outputs clear asynchronously. Counting restarts from 0 after reset deasserts.

## Configuration
- Macro: `AXIS_BLOCK_STICKY_EN`.
- Defined: BLOCKED is terminal. A channel stays blocked, and `axis_block_sigs[c]` stays high, until reset, regardless of later transfers or `inst_idle`. This is for post-mortem capture.
- Undefined: release behaviour exactly as in Operation.

## Structure
- Shared package `deadlock_pkg` holds:
  - Enum `stall_state_t` {IDLE, STALL, BLOCKED}.
  - Constants `DIR_IN` = 1'b1 and `DIR_OUT` = 1'b0.
- Sub-module `axis_stall_chan`: one channel's FSM, counter and stall decode, parameterised by THRESH and direction. It is instantiated N_CH times in a generate loop.
- The top level contains only the `any_block` OR and the first-block priority capture.

## Test plan
- THRESH=16, channel 0 input with `tready`=1 and `tvalid`=0 held for 20 cycles → `axis_block_sigs` = 3'b001 from cycle 16, `first_ch` = 0, `first_vld` = 1.
- Output channel 1 back-pressured for 15 cycles, then one transfer, then 15 more → block never asserts and the counter restarts at 0.
- Channels 1 and 2 stalled starting on the same edge → both block together, and `first_ch` = 1.
- Channel 2 blocked, then `inst_idle`=1 for one cycle → block drops on the next cycle. With `AXIS_BLOCK_STICKY_EN` defined it stays 1.
- Reset asserted at stall cycle 10 of 16 and released → outputs 0 immediately. Blocking needs a fresh 16 stalled cycles.
- THRESH=1, a single stall edge on channel 0 → block after that edge, and it clears on the following transfer.

Source files
------------

// File: rtl/axis_stall_block_gen_pkg.sv
// Shared types for the AXIS stall/deadlock detection blocks.
// Holds the channel state encoding, direction constants and an index-width helper.
package deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    BLOCKED = 2'd2
  } stall_state_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Width of a channel index, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_stall_block_gen_if.sv
// Stream-watch bundle for axis_stall_block_gen: monitored handshakes and idle flag in,
// block flags and first-block capture out.
interface axis_stall_block_gen_if #(
  parameter int N_CH = 3
);
  import deadlock_pkg::*;

  localparam int FC_W = idx_w(N_CH);

  logic [N_CH-1:0] axis_tvalid;
  logic [N_CH-1:0] axis_tready;
  logic            inst_idle;
  logic [N_CH-1:0] axis_block_sigs;
  logic            any_block;
  logic [FC_W-1:0] first_ch;
  logic            first_vld;

  modport master (
    output axis_tvalid, axis_tready, inst_idle,
    input  axis_block_sigs, any_block, first_ch, first_vld
  );

  modport slave (
    input  axis_tvalid, axis_tready, inst_idle,
    output axis_block_sigs, any_block, first_ch, first_vld
  );

endinterface

// File: rtl/axis_stall_block_gen_chan.sv
// One monitored AXIS channel: stall decode, saturating stall counter and IDLE/STALL/BLOCKED FSM.
// AXIS_BLOCK_STICKY_EN makes BLOCKED terminal until reset.
module axis_stall_chan
  import deadlock_pkg::*;
#(
  parameter int   THRESH = 16,
  parameter logic DIR    = DIR_IN,
  parameter int   CNT_W  = $clog2(THRESH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic tvalid,
  input  logic tready,
  input  logic inst_idle,
  output logic block,
  output logic block_nxt
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  stall_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             stall;

  // Input channels stall when starved, output channels when back-pressured.
  assign stall   = ~inst_idle & ((DIR == DIR_IN) ? (tready & ~tvalid) : (tvalid & ~tready));
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stall) begin
          cnt_d   = CNT_W'(1);
          state_d = (THRESH == 1) ? BLOCKED : STALL;
        end else begin
          cnt_d = '0;
        end
      end
      STALL: begin
        if (stall) begin
          cnt_d = cnt_inc;
          if (cnt_inc == THRESH_C) state_d = BLOCKED;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      BLOCKED: begin
        cnt_d = THRESH_C;
`ifdef AXIS_BLOCK_STICKY_EN
        state_d = BLOCKED;
`else
        if (!stall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    block     = (state_q == BLOCKED);
    block_nxt = (state_d == BLOCKED);
  end

endmodule

// File: rtl/axis_stall_block_gen.sv
// Per-channel AXIS stall detector feeding the deadlock monitor: any_block OR and first-block capture.
// Optional AXIS_BLOCK_STICKY_EN (in axis_stall_chan) latches blocks until reset.
module axis_stall_block_gen
  import deadlock_pkg::*;
#(
  parameter int              N_CH     = 3,
  parameter int              THRESH   = 16,
  parameter logic [N_CH-1:0] DIR_MASK = 3'b001,
  parameter int              CNT_W    = $clog2(THRESH + 1)
) (
  input logic                  clock,
  input logic                  reset,
  axis_stall_block_gen_if.slave bus
);

  localparam int FC_W = idx_w(N_CH);

  logic [N_CH-1:0] blk, blk_nxt;
  logic [FC_W-1:0] first_idx;

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    axis_stall_chan #(
      .THRESH (THRESH),
      .DIR    (DIR_MASK[c]),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .tvalid    (bus.axis_tvalid[c]),
      .tready    (bus.axis_tready[c]),
      .inst_idle (bus.inst_idle),
      .block     (blk[c]),
      .block_nxt (blk_nxt[c])
    );
  end

  assign bus.axis_block_sigs = blk;

  // Descending scan so the lowest blocking index is the one left standing.
  always_comb begin
    first_idx = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (blk_nxt[c]) first_idx = FC_W'(c);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.any_block <= 1'b0;
      bus.first_ch  <= '0;
      bus.first_vld <= 1'b0;
    end else begin
      bus.any_block <= |blk_nxt;
      if (!bus.first_vld && (|blk_nxt)) begin
        bus.first_vld <= 1'b1;
        bus.first_ch  <= first_idx;
      end
    end
  end

endmodule

// File: tb/tb_axis_stall_block_gen.sv
// Directed bench for axis_stall_block_gen: table of held-input runs plus hand sequences
// for same-edge blocking, asynchronous reset mid-stall and THRESH=1.
module tb_axis_stall_block_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

`ifdef AXIS_BLOCK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  axis_stall_block_gen_if #(.N_CH(3)) bus0 ();
  axis_stall_block_gen_if #(.N_CH(3)) bus1 ();

  axis_stall_block_gen #(.N_CH(3), .THRESH(16), .DIR_MASK(3'b001)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  axis_stall_block_gen #(.N_CH(3), .THRESH(1), .DIR_MASK(3'b001)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic [2:0] tv;
    logic [2:0] tr;
    logic       idle;
    int         n;
    logic [2:0] blk;
    logic [2:0] blk_s;
    logic       fvld;
    logic [1:0] fch;
  } vec_t;

  vec_t tbl[16];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit sel, input logic [2:0] tv, input logic [2:0] tr, input logic idle);
    if (sel) begin
      bus1.axis_tvalid = tv; bus1.axis_tready = tr; bus1.inst_idle = idle;
    end else begin
      bus0.axis_tvalid = tv; bus0.axis_tready = tr; bus0.inst_idle = idle;
    end
  endtask

  task automatic check_out(input bit sel, input string tag, input logic [2:0] blk,
                           input logic fvld, input logic [1:0] fch);
    logic [2:0] a_blk;
    logic       a_any, a_fvld;
    logic [1:0] a_fch;
    if (sel) begin
      a_blk = bus1.axis_block_sigs; a_any = bus1.any_block; a_fvld = bus1.first_vld; a_fch = bus1.first_ch;
    end else begin
      a_blk = bus0.axis_block_sigs; a_any = bus0.any_block; a_fvld = bus0.first_vld; a_fch = bus0.first_ch;
    end
    chk({tag, " block_sigs"}, 32'(a_blk), 32'(blk));
    chk({tag, " any_block"}, 32'(a_any), 32'(|blk));
    chk({tag, " first_vld"}, 32'(a_fvld), 32'(fvld));
    chk({tag, " first_ch"}, 32'(a_fch), 32'(fch));
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
  endtask

  initial begin
    //          tv      tr      idle  n   blk     blk_s   fvld  fch
    tbl[0]  = '{3'b000, 3'b000, 1'b0, 2,  3'b000, 3'b000, 1'b0, 2'd0};
    tbl[1]  = '{3'b000, 3'b001, 1'b0, 15, 3'b000, 3'b000, 1'b0, 2'd0};
    tbl[2]  = '{3'b000, 3'b001, 1'b0, 1,  3'b001, 3'b001, 1'b1, 2'd0};
    tbl[3]  = '{3'b000, 3'b001, 1'b0, 4,  3'b001, 3'b001, 1'b1, 2'd0};
    tbl[4]  = '{3'b001, 3'b001, 1'b0, 1,  3'b000, 3'b001, 1'b1, 2'd0};
    tbl[5]  = '{3'b010, 3'b000, 1'b0, 15, 3'b000, 3'b001, 1'b1, 2'd0};
    tbl[6]  = '{3'b010, 3'b010, 1'b0, 1,  3'b000, 3'b001, 1'b1, 2'd0};
    tbl[7]  = '{3'b010, 3'b000, 1'b0, 15, 3'b000, 3'b001, 1'b1, 2'd0};
    tbl[8]  = '{3'b010, 3'b000, 1'b0, 1,  3'b010, 3'b011, 1'b1, 2'd0};
    tbl[9]  = '{3'b000, 3'b000, 1'b0, 1,  3'b000, 3'b011, 1'b1, 2'd0};
    tbl[10] = '{3'b100, 3'b000, 1'b0, 16, 3'b100, 3'b111, 1'b1, 2'd0};
    tbl[11] = '{3'b100, 3'b000, 1'b1, 1,  3'b000, 3'b111, 1'b1, 2'd0};
    tbl[12] = '{3'b100, 3'b000, 1'b0, 15, 3'b000, 3'b111, 1'b1, 2'd0};
    tbl[13] = '{3'b100, 3'b000, 1'b0, 1,  3'b100, 3'b111, 1'b1, 2'd0};
    tbl[14] = '{3'b100, 3'b100, 1'b1, 1,  3'b000, 3'b111, 1'b1, 2'd0};
    tbl[15] = '{3'b000, 3'b000, 1'b0, 1,  3'b000, 3'b111, 1'b1, 2'd0};

    drive(1'b0, 3'b000, 3'b000, 1'b0);
    drive(1'b1, 3'b000, 3'b000, 1'b0);
    #12;
    check_out(1'b0, "reset t16", 3'b000, 1'b0, 2'd0);
    check_out(1'b1, "reset t1", 3'b000, 1'b0, 2'd0);
    @(negedge clock) reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, tbl[i].tv, tbl[i].tr, tbl[i].idle);
      run(tbl[i].n);
      check_out(1'b0, $sformatf("row%0d", i), STICKY ? tbl[i].blk_s : tbl[i].blk,
                tbl[i].fvld, tbl[i].fch);
    end

    // Channels 1 and 2 stall from the same edge; lowest index is captured.
    drive(1'b0, 3'b000, 3'b000, 1'b0);
    pulse_reset();
    drive(1'b0, 3'b110, 3'b000, 1'b0);
    run(15);
    check_out(1'b0, "dual pre", 3'b000, 1'b0, 2'd0);
    run(1);
    check_out(1'b0, "dual blk", 3'b110, 1'b1, 2'd1);
    run(3);
    check_out(1'b0, "dual hold", 3'b110, 1'b1, 2'd1);

    // Asynchronous reset while blocked, then mid-count at stall cycle 10.
    drive(1'b0, 3'b000, 3'b000, 1'b0);
    pulse_reset();
    drive(1'b0, 3'b000, 3'b001, 1'b0);
    run(16);
    check_out(1'b0, "pre rst blk", 3'b001, 1'b1, 2'd0);
    reset = 1'b1;
    #1;
    check_out(1'b0, "async rst", 3'b000, 1'b0, 2'd0);
    @(negedge clock) reset = 1'b0;
    run(10);
    reset = 1'b1;
    #1;
    check_out(1'b0, "rst cyc10", 3'b000, 1'b0, 2'd0);
    @(negedge clock) reset = 1'b0;
    run(15);
    check_out(1'b0, "restart 15", 3'b000, 1'b0, 2'd0);
    run(1);
    check_out(1'b0, "restart 16", 3'b001, 1'b1, 2'd0);

    // THRESH=1 instance: one stall edge blocks, next transfer releases.
    drive(1'b0, 3'b000, 3'b000, 1'b0);
    pulse_reset();
    run(1);
    check_out(1'b1, "t1 quiet", 3'b000, 1'b0, 2'd0);
    drive(1'b1, 3'b000, 3'b001, 1'b0);
    run(1);
    check_out(1'b1, "t1 stall", 3'b001, 1'b1, 2'd0);
    drive(1'b1, 3'b001, 3'b001, 1'b0);
    run(1);
    check_out(1'b1, "t1 xfer", STICKY ? 3'b001 : 3'b000, 1'b1, 2'd0);
    drive(1'b1, 3'b010, 3'b000, 1'b0);
    run(1);
    check_out(1'b1, "t1 ch1", STICKY ? 3'b011 : 3'b010, 1'b1, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
